// File: rtl/cordic_pkg.sv
// cordic_pkg
// Types and constants shared by the CORDIC top level and its result FIFO.
//   WIDTH    : half-precision float width of each cos/sin result
//   FLIP_W   : width of the quadrant/flip code
//   result_t : one CORDIC result {sin, cos, flip}
package cordic_pkg;

    localparam int WIDTH  = 16;
    localparam int FLIP_W = 3;

    typedef struct packed {
        logic [WIDTH-1:0]  sin;
        logic [WIDTH-1:0]  cos;
        logic [FLIP_W-1:0] flip;
    } result_t;

    localparam int RESULT_W = $bits(result_t);

    // Assemble a result from the raw CORDIC outputs.
    function automatic result_t pack_result(input logic [WIDTH-1:0]  sin_v,
                                            input logic [WIDTH-1:0]  cos_v,
                                            input logic [FLIP_W-1:0] flip_v);
        result_t r;
        r.sin  = sin_v;
        r.cos  = cos_v;
        r.flip = flip_v;
        return r;
    endfunction

endpackage

// File: rtl/cordic_result_fifo_if.sv
// cordic_result_fifo_if
// Consumer-side valid/ready handshake of the CORDIC result FIFO.
//   out_valid : head entry is valid
//   out_data  : head result {sin, cos}, sin in [31:16]
//   out_flip  : head flip code
//   out_ready : consumer accepts the head entry
// master = FIFO side, slave = consumer side.
interface cordic_result_fifo_if;

    logic        out_valid;
    logic [31:0] out_data;
    logic [2:0]  out_flip;
    logic        out_ready;

    modport master (output out_valid, output out_data, output out_flip, input out_ready);
    modport slave  (input out_valid, input out_data, input out_flip, output out_ready);

endinterface

// File: rtl/cordic_fifo_mem.sv
// cordic_fifo_mem
// DEPTH x result_t register array: synchronous write port, asynchronous read port.
//   clk     : write clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : result to store
//   rd_addr : read address
//   rd_data : result at rd_addr (combinational)
// Contents are intentionally not reset.
module cordic_fifo_mem
    import cordic_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  result_t                  wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output result_t                  rd_data
);

    result_t mem_r [DEPTH];

    // Storage write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/cordic_result_fifo.sv
// cordic_result_fifo
// First-word-fall-through buffer for CORDIC results with headroom back-pressure.
//   clk, rst          : clock, synchronous active-high reset
//   done_in           : result strobe; cos_in/sin_in/flip_in valid this cycle
//   ready_up          : upstream may issue a new angle ((DEPTH-count) > INFLIGHT)
//   res (master)      : out_valid/out_data/out_flip/out_ready consumer handshake
//   count             : current occupancy
//   overflow          : sticky, a result was dropped because the FIFO was full
//   ovf_count         : saturating drop counter, present only when
//                       CORDIC_RESULT_OVF_CNT_EN is defined
// All outputs are registered. The head is held in a register that is loaded
// with the entry that will be at the head after each edge, so out_data is 0
// after reset and keeps the last popped value while empty.
module cordic_result_fifo
    import cordic_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int INFLIGHT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       done_in,
    input  logic [WIDTH-1:0]           cos_in,
    input  logic [WIDTH-1:0]           sin_in,
    input  logic [FLIP_W-1:0]          flip_in,
    output logic                       ready_up,
    cordic_result_fifo_if.master       res,
    output logic [$clog2(DEPTH+1)-1:0] count,
`ifdef CORDIC_RESULT_OVF_CNT_EN
    output logic [7:0]                 ovf_count,
`endif
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0] rd_ptr_r, wr_ptr_r, rd_ptr_next_s, wr_ptr_next_s;
    logic [CW-1:0] count_r, count_next_s;
    logic          out_valid_r, ready_up_r, overflow_r;
    result_t       head_r, head_next_s, push_data_s, rd_data_s;
    logic          full_s, pop_s, push_s, drop_s, bypass_s;

    assign full_s      = (count_r == CW'(DEPTH));
    assign pop_s       = out_valid_r & res.out_ready;
    assign push_s      = done_in & (~full_s | pop_s);
    assign drop_s      = done_in & full_s & ~pop_s;
    assign push_data_s = pack_result(sin_in, cos_in, flip_in);

    cordic_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .wr_en   (push_s & ~rst),
        .wr_addr (wr_ptr_r),
        .wr_data (push_data_s),
        .rd_addr (rd_ptr_next_s),
        .rd_data (rd_data_s)
    );

    // Next occupancy and pointer values.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1'b1);
            2'b01:   count_next_s = count_r - CW'(1'b1);
            default: count_next_s = count_r;
        endcase
        if (pop_s) begin
            rd_ptr_next_s = rd_ptr_r + AW'(1'b1);
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
        if (push_s) begin
            wr_ptr_next_s = wr_ptr_r + AW'(1'b1);
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end
    end

    // Next head entry: when the pushed entry lands exactly at the next read
    // pointer (FIFO empty after any pop) it is not yet in memory, so forward it.
    always_comb begin
        bypass_s = push_s & (rd_ptr_next_s == wr_ptr_r);
        if (bypass_s) begin
            head_next_s = push_data_s;
        end else begin
            head_next_s = rd_data_s;
        end
    end

    // Pointer, occupancy, flag and head registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r    <= '0;
            wr_ptr_r    <= '0;
            count_r     <= '0;
            out_valid_r <= 1'b0;
            ready_up_r  <= 1'b1;
            overflow_r  <= 1'b0;
            head_r      <= '0;
        end else begin
            rd_ptr_r    <= rd_ptr_next_s;
            wr_ptr_r    <= wr_ptr_next_s;
            count_r     <= count_next_s;
            out_valid_r <= (count_next_s != '0);
            ready_up_r  <= ((DEPTH - int'(count_next_s)) > INFLIGHT);
            if (count_next_s != '0) begin
                head_r <= head_next_s;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

`ifdef CORDIC_RESULT_OVF_CNT_EN
    logic [7:0] ovf_count_r;

    // Saturating count of dropped results.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_count_r <= 8'd0;
        end else if (drop_s && (ovf_count_r != 8'hFF)) begin
            ovf_count_r <= ovf_count_r + 8'd1;
        end
    end

    assign ovf_count = ovf_count_r;
`endif

    assign count         = count_r;
    assign ready_up      = ready_up_r;
    assign overflow      = overflow_r;
    assign res.out_valid = out_valid_r;
    assign res.out_data  = {head_r.sin, head_r.cos};
    assign res.out_flip  = head_r.flip;

endmodule
